// File: rtl/asm_precomp_scheduler_if.sv
// Request/result bundle for the shared B-multiple precompute unit.
// Requesters and the result consumer sit on the master side.
interface asm_precomp_scheduler_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [ID_W-1:0]          out_id;
  logic [WIDTH+2:0]         out_i1;
  logic [WIDTH+2:0]         out_i3;
  logic [WIDTH+2:0]         out_i5;
  logic [WIDTH+2:0]         out_i7;

  modport master (
    output req_valid, req_b, out_ready,
    input  req_ready, out_valid, out_id,
    input  out_i1, out_i3, out_i5, out_i7
  );

  modport slave (
    input  req_valid, req_b, out_ready,
    output req_ready, out_valid, out_id,
    output out_i1, out_i3, out_i5, out_i7
  );
endinterface

// File: rtl/asm_precomp_scheduler.sv
// Round-robin shared 1x/3x/5x/7x precompute with a two-stage
// valid/ready pipeline and requester-tagged results.
module asm_precomp_scheduler #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  asm_precomp_scheduler_if.slave bus,
  output logic                   busy,
  output logic [CNT_W-1:0]       xfer_cnt
);
  localparam int OW = WIDTH + 3;

  typedef struct packed {
    logic [WIDTH-1:0] b;
    logic [ID_W-1:0]  id;
    logic             vld;
  } stg_a_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [OW-1:0]   i1;
    logic [OW-1:0]   i3;
    logic [OW-1:0]   i5;
    logic [OW-1:0]   i7;
    logic            vld;
  } stg_b_t;

  stg_a_t          sa;
  stg_b_t          sb;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt;
  logic            found;
  logic            adv_b;
  logic            accept_a;
  logic            take;
  logic [WIDTH-1:0] b_sel;
  logic [OW-1:0]   ext;
  logic [OW-1:0]   m3;
  logic [OW-1:0]   m5;
  logic [OW-1:0]   m7;

  // Pointer arithmetic wraps naturally since NUM_REQ is a power of two.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[ptr + ID_W'(k)]) begin
        found = 1'b1;
        gnt   = ptr + ID_W'(k);
      end
    end
  end

  assign adv_b    = sa.vld & (~sb.vld | bus.out_ready);
  assign accept_a = ~sa.vld | adv_b;
  assign take     = accept_a & found;

  always_comb begin
    bus.req_ready = '0;
    b_sel         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == ID_W'(i)) begin
        bus.req_ready[i] = take;
        b_sel = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign ext = {3'b000, sa.b};
  assign m3  = ext + (ext << 1);
  assign m5  = ext + (ext << 2);
  assign m7  = (ext << 3) - ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      ptr      <= '0;
      xfer_cnt <= '0;
    end else begin
      if (accept_a) begin
        sa.vld <= take;
        if (take) begin
          sa.b  <= b_sel;
          sa.id <= gnt;
          ptr   <= gnt + ID_W'(1);
        end
      end
      if (adv_b) begin
        sb <= '{id: sa.id, i1: ext, i3: m3,
                i5: m5, i7: m7, vld: 1'b1};
      end else if (bus.out_ready) begin
        sb.vld <= 1'b0;
      end
      if (sb.vld & bus.out_ready) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = sb.vld;
  assign bus.out_id    = sb.id;
  assign bus.out_i1    = sb.i1;
  assign bus.out_i3    = sb.i3;
  assign bus.out_i5    = sb.i5;
  assign bus.out_i7    = sb.i7;
  assign busy          = sa.vld | sb.vld;
endmodule

// File: tb/tb_asm_precomp_scheduler.sv
// Randomized bench for asm_precomp_scheduler: a depth-2,
// min-latency-2 queue model predicts grants and results.
module tb_asm_precomp_scheduler;
  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 4;
  localparam int OW  = W + 3;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic [CW-1:0] xfer_cnt;

  always #5 clk = ~clk;

  asm_precomp_scheduler_if #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW)) bus ();

  asm_precomp_scheduler #(
    .WIDTH(W), .NUM_REQ(N), .ID_W(IDW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .xfer_cnt(xfer_cnt)
  );

  typedef struct {
    int id;
    int b;
    int age;
  } item_t;

  item_t q[$];
  int ptr_m;
  int cnt_m;
  int mode;
  int total = 0;
  int bad = 0;
  logic [W-1:0] rb[N];
  logic rv[N];

  logic [N-1:0]   o_ready;
  logic           o_valid;
  logic [OW-1:0]  o_i1, o_i3, o_i5, o_i7;
  logic [OW-1:0]  i3_log[$];
  logic [IDW-1:0] id_log[$];
  logic [OW-1:0]  i1_log[$];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = rv[i];
      bus.req_b[i*W +: W] = rb[i];
    end
  endtask

  task automatic model_clear();
    q.delete();
    i3_log.delete();
    id_log.delete();
    i1_log.delete();
    ptr_m = 0;
    cnt_m = 0;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0;
      rb[i] = '0;
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: compare at negedge, advance model at posedge.
  task automatic run_cycle();
    int g;
    logic [N-1:0] er;
    bit vis;
    item_t it;
    logic [IDW+4*OW-1:0] ev;
    logic [IDW+4*OW-1:0] av;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && rv[(ptr_m + k) % N]) g = (ptr_m + k) % N;
    er = '0;
    if (g >= 0 && (q.size() < 2 || bus.out_ready)) er[g] = 1'b1;
    vis = q.size() > 0 && q[0].age >= 2;
    o_ready = bus.req_ready;
    o_valid = bus.out_valid;
    o_i1 = bus.out_i1;
    o_i3 = bus.out_i3;
    o_i5 = bus.out_i5;
    o_i7 = bus.out_i7;
    if (bus.out_valid) i3_log.push_back(bus.out_i3);
    if (bus.out_valid && bus.out_ready) begin
      id_log.push_back(bus.out_id);
      i1_log.push_back(bus.out_i1);
    end
    total++;
    if (bus.req_ready !== er) begin
      bad++;
      $display("FAIL req_ready got=%b exp=%b t=%0t", bus.req_ready, er, $time);
    end
    total++;
    if (bus.out_valid !== vis) begin
      bad++;
      $display("FAIL out_valid got=%b exp=%b t=%0t", bus.out_valid, vis, $time);
    end
    if (vis) begin
      ev = {IDW'(q[0].id), OW'(q[0].b), OW'(q[0].b * 3),
            OW'(q[0].b * 5), OW'(q[0].b * 7)};
      av = {bus.out_id, bus.out_i1, bus.out_i3, bus.out_i5, bus.out_i7};
      total++;
      if (av !== ev) begin
        bad++;
        $display("FAIL out_data got=%h exp=%h t=%0t", av, ev, $time);
      end
    end
    total++;
    if (busy !== (q.size() > 0)) begin
      bad++;
      $display("FAIL busy got=%b exp=%b t=%0t", busy, q.size() > 0, $time);
    end
    total++;
    if (xfer_cnt !== CW'(cnt_m)) begin
      bad++;
      $display("FAIL xfer_cnt got=%0d exp=%0d t=%0t", xfer_cnt, CW'(cnt_m), $time);
    end
    @(posedge clk);
    if (vis && bus.out_ready) begin
      void'(q.pop_front());
      cnt_m++;
    end
    if (er != '0) begin
      it.id = g;
      it.b = int'(rb[g]);
      it.age = 0;
      q.push_back(it);
      ptr_m = (g + 1) % N;
    end
    foreach (q[i]) q[i].age++;
    #1;
    if (er != '0 && mode != 1) rv[g] = 1'b0;
    if (mode == 2) begin
      for (int i = 0; i < N; i++)
        if (!rv[i]) begin
          rv[i] = ($urandom % 3) == 0;
          rb[i] = W'($urandom);
        end
      bus.out_ready = ($urandom % 4) != 0;
    end
    drive();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || xfer_cnt !== '0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b%b%0d exp=000", bus.out_valid, busy, xfer_cnt);
    end
    total++;
    if ({bus.out_id, bus.out_i1, bus.out_i3, bus.out_i5, bus.out_i7} !== '0
        || bus.req_ready !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", {bus.out_i1, bus.out_i7});
    end
  endtask

  task automatic test_single();
    do_reset();
    mode = 0;
    bus.out_ready = 1'b1;
    rv[0] = 1'b1;
    rb[0] = 8'hFF;
    drive();
    repeat (3) run_cycle();
    total++;
    if ({o_valid, o_i1, o_i3, o_i5, o_i7} !== {1'b1, 11'h0FF, 11'h2FD, 11'h4FB, 11'h6F9}) begin
      bad++;
      $display("FAIL single_ff got=%b %h %h %h %h", o_valid, o_i1, o_i3, o_i5, o_i7);
    end
    total++;
    if (xfer_cnt !== 4'd1) begin
      bad++;
      $display("FAIL single_cnt got=%0d exp=1", xfer_cnt);
    end
  endtask

  task automatic test_edges();
    do_reset();
    mode = 0;
    bus.out_ready = 1'b1;
    rv[3] = 1'b1;
    rb[3] = 8'h00;
    drive();
    repeat (3) run_cycle();
    total++;
    if ({o_valid, o_i1, o_i3, o_i5, o_i7} !== {1'b1, 44'h0}) begin
      bad++;
      $display("FAIL edge_zero got=%b %h %h %h %h", o_valid, o_i1, o_i3, o_i5, o_i7);
    end
    rv[1] = 1'b1;
    rb[1] = 8'h80;
    drive();
    repeat (3) run_cycle();
    total++;
    if ({o_valid, o_i3, o_i5, o_i7} !== {1'b1, 11'h180, 11'h280, 11'h380}) begin
      bad++;
      $display("FAIL edge_80 got=%b %h %h %h", o_valid, o_i3, o_i5, o_i7);
    end
  endtask

  task automatic test_fairness();
    logic [OW-1:0] exp_i3[5] = '{11'd3, 11'd6, 11'd9, 11'd12, 11'd3};
    do_reset();
    mode = 1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b1;
      rb[i] = W'(i + 1);
    end
    drive();
    repeat (7) run_cycle();
    total++;
    if (i3_log.size() != 5) begin
      bad++;
      $display("FAIL fair_count got=%0d exp=5", i3_log.size());
    end
    for (int i = 0; i < 5 && i < i3_log.size(); i++) begin
      total++;
      if (i3_log[i] !== exp_i3[i]) begin
        bad++;
        $display("FAIL fair_i3[%0d] got=%0d exp=%0d", i, i3_log[i], exp_i3[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 0;
    rv[0] = 1'b1;
    rb[0] = 8'd10;
    rv[1] = 1'b1;
    rb[1] = 8'd20;
    drive();
    repeat (2) run_cycle();
    rv[2] = 1'b1;
    rb[2] = 8'd30;
    drive();
    for (int c = 0; c < 5; c++) begin
      run_cycle();
      total++;
      if ({o_ready, o_valid, o_i1} !== {4'b0000, 1'b1, 11'd10}) begin
        bad++;
        $display("FAIL bp_hold got=%b %b %0d exp=0000 1 10", o_ready, o_valid, o_i1);
      end
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && id_log.size() < 3; c++) run_cycle();
    total++;
    if (id_log.size() != 3) begin
      bad++;
      $display("FAIL bp_count got=%0d exp=3", id_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (id_log[i] !== IDW'(i) || i1_log[i] !== OW'(10 * (i + 1))) begin
          bad++;
          $display("FAIL bp_order[%0d] got=%0d/%0d exp=%0d/%0d", i, id_log[i], i1_log[i], i, 10 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    mode = 0;
    rv[0] = 1'b1;
    rb[0] = 8'd7;
    rv[1] = 1'b1;
    rb[1] = 8'd9;
    drive();
    repeat (2) run_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midop_async got=%b%b exp=00", bus.out_valid, busy);
    end
    model_clear();
    rv[2] = 1'b1;
    rb[2] = 8'd3;
    rv[0] = 1'b1;
    rb[0] = 8'd4;
    drive();
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    run_cycle();
    total++;
    if (o_ready !== 4'b0001) begin
      bad++;
      $display("FAIL midop_grant got=%b exp=0001", o_ready);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    mode = 1;
    bus.out_ready = 1'b1;
    rv[1] = 1'b1;
    rb[1] = 8'd5;
    drive();
    for (int c = 0; c < 40 && cnt_m < 17; c++) run_cycle();
    total++;
    if (xfer_cnt !== 4'd1 || cnt_m != 17) begin
      bad++;
      $display("FAIL cnt_wrap got=%0d exp=1 (transfers=%0d)", xfer_cnt, cnt_m);
    end
  endtask

  task automatic test_random();
    do_reset();
    mode = 2;
    for (int c = 0; c < 400; c++) run_cycle();
    mode = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    drive();
    for (int c = 0; c < 5; c++) run_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    mode = 0;
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_edges();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    test_counter_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/asm_precomp_scheduler.md
Name: asm_precomp_scheduler

Overview:
- Shares one alphabet-set pre-computation datapath (1x, 3x, 5x, 7x multiples of an operand B) among NUM_REQ requesters, such as PE rows that need fresh B multiples.
- Round-robin arbiter; two-stage registered pipeline with valid/ready backpressure; tagged results.
- Sits between the operand fetch logic and the ASM multiplier arrays.

Parameters:
- WIDTH, 8, operand width of B.
- NUM_REQ, 4, number of requesters (power of two, at least 2).
- ID_W, $clog2(NUM_REQ), requester tag width.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_b  input  NUM_REQ*WIDTH  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot accept; at most one bit high per cycle.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- out_id  output  ID_W  index of the requester that owns the result.
- out_i1, out_i3, out_i5, out_i7  output  WIDTH+3 each  B*1, B*3, B*5, B*7.
- busy  output  1  high when either pipeline stage holds valid data.
- xfer_cnt  output  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Both stage valids = 0 and out_valid = 0.
  - All data registers, out_id, out_i* = 0; xfer_cnt = 0; busy = 0.
  - Round-robin pointer = 0.
  - A reset mid-operation discards all in-flight requests; none are replayed.
- Arithmetic: unsigned. i1 = zero-extended B; i3 = B + (B<<1); i5 = B + (B<<2); i7 = (B<<3) - B; all computed at WIDTH+3 bits. The results never overflow because 7*(2^WIDTH-1) < 2^(WIDTH+3).
- Stage A (capture): registers {B, id, valid_a}.
- Stage B (output): registers {id, i1, i3, i5, i7, valid_b}. Multiples are computed combinationally from the stage A contents and registered here. out_valid = valid_b.
- Advance rules:
  - advance_b = valid_a & (!valid_b | out_ready).
  - accept_a = !valid_a | advance_b.
  - A stage with no incoming data and whose contents moved on clears its valid.
- Arbitration:
  - Among asserted req_valid bits, grant the first index at or after the pointer, scanning upward with wrap.
  - req_ready[g] = accept_a & req_valid[g] for the granted index g; every other bit is 0.
  - req_ready may depend combinationally on req_valid and out_ready.
  - On an accept, pointer <= (g+1) mod NUM_REQ. With no accept, the pointer holds.
- Requester rules:
  - Once a requester raises req_valid, it holds req_valid and req_b stable until it sees req_ready.
  - A requester cannot be granted twice while another requester is waiting, provided the waiting requester holds valid.
- Latency and throughput:
  - Accept at edge k gives out_valid at edge k+2 when there is no backpressure.
  - Sustained throughput is 1 result per cycle.
- Output hold: while out_valid & !out_ready, all out_* hold stable. Stage A may still accept one request if it is empty.
- Full condition: valid_a & valid_b & !out_ready gives all req_ready = 0.
- Simultaneous events: an output handshake and a new accept in the same cycle are both honoured, with no bubble.
- xfer_cnt increments on each out_valid & out_ready and wraps modulo 2^CNT_W.
- busy = valid_a | valid_b.

Test Plan:
- Single request (WIDTH=8): req 0 with B=0xFF, out_ready=1 -> two cycles after accept: out_id=0, i1=0x0FF, i3=0x2FD, i5=0x4FB, i7=0x6F9; xfer_cnt=1.
- Fairness: all four requesters hold valid with B=1,2,3,4 -> grants in order 0,1,2,3,0,...; out_i3 sequence 3,6,9,12,3; one result per cycle.
- Backpressure: two requests accepted, then out_ready=0 for 5 cycles -> out_* stable, all req_ready=0 once both stages are full; after out_ready=1, both results are delivered in order with no loss or duplication.
- Edge operands: B=0 -> all outputs 0. B=0x80 -> i3=0x180, i5=0x280, i7=0x380.
- Reset mid-operation: rst_n low while both stages are valid -> out_valid and busy drop to 0 without a clock edge. After release, with requesters 2 and 0 both requesting, the first grant goes to requester 0.
- Counter wrap (CNT_W=4): 17 completed transfers -> xfer_cnt=1.
